// File: rtl/fetch_ctrl_if.sv
// Fetch controller bus bundle: instruction-memory request side, decode side,
// and control-flow inputs. master = fetch_ctrl, slave = memory/decode/resolver.
interface fetch_ctrl_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic [31:0] imem_rdata;
  logic        instr_valid;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic [31:0] instr_pc_plus4;
  logic        instr_ready;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        halt;
  logic        halted;
  logic        align_err;

  modport master (
    output imem_req, imem_addr, instr_valid, instr, instr_pc, instr_pc_plus4,
           halted, align_err,
    input  imem_ready, imem_rdata, instr_ready, redirect, redirect_pc, halt
  );

  modport slave (
    input  imem_req, imem_addr, instr_valid, instr, instr_pc, instr_pc_plus4,
           halted, align_err,
    output imem_ready, imem_rdata, instr_ready, redirect, redirect_pc, halt
  );
endinterface

// File: rtl/fetch_ctrl.sv
// Instruction-fetch sequencer: owns the PC, fetches over a variable-latency
// memory handshake and holds each instruction for decode until accepted.
module fetch_ctrl #(
  parameter logic [31:0] RESET_PC = 32'h0000_3000
) (
  input  logic         clk,
  input  logic         clr,
  fetch_ctrl_if.master bus
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_HOLD  = 2'd2,
    S_HALT  = 2'd3
  } state_t;

  state_t      state_q;
  logic [31:0] pc_q;
  logic [31:0] instr_q;
  logic [31:0] instr_pc_q;
  logic        align_err_q;

  logic [31:0] pc_inc_d;
  logic [31:0] redir_pc_d;
  logic        redir_misaligned_d;

  assign pc_inc_d           = pc_q + 32'd4;
  assign redir_pc_d         = {bus.redirect_pc[31:2], 2'b00};
  assign redir_misaligned_d = (bus.redirect_pc[1:0] != 2'b00);

  // Priority: reset > redirect > halt > handshake.
  always_ff @(posedge clk) begin
    if (!clr) begin
      state_q     <= S_IDLE;
      pc_q        <= RESET_PC;
      instr_q     <= '0;
      instr_pc_q  <= '0;
      align_err_q <= 1'b0;
    end else if (bus.redirect) begin
      // A same-cycle memory response or held instruction is dropped here.
      state_q <= S_FETCH;
      pc_q    <= redir_pc_d;
      if (redir_misaligned_d) begin
        align_err_q <= 1'b1;
      end
    end else begin
      unique case (state_q)
        S_IDLE: begin
          state_q <= bus.halt ? S_HALT : S_FETCH;
        end
        S_FETCH: begin
          if (bus.imem_ready) begin
            instr_q    <= bus.imem_rdata;
            instr_pc_q <= pc_q;
            state_q    <= S_HOLD;
          end
        end
        S_HOLD: begin
          if (bus.instr_ready) begin
            pc_q    <= pc_inc_d;
            state_q <= bus.halt ? S_HALT : S_FETCH;
          end
        end
        S_HALT: begin
          state_q <= S_HALT;
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.imem_req       = (state_q == S_FETCH);
  assign bus.imem_addr      = pc_q;
  assign bus.instr_valid    = (state_q == S_HOLD);
  assign bus.instr          = instr_q;
  assign bus.instr_pc       = instr_pc_q;
  assign bus.instr_pc_plus4 = instr_pc_q + 32'd4;
  assign bus.halted         = (state_q == S_HALT);
  assign bus.align_err      = align_err_q;

endmodule

// File: tb/tb_fetch_ctrl.sv
// Scoreboard bench for fetch_ctrl: a transaction-level model predicts per-cycle
// status and fetched instructions; a monitor pops and compares them.
module tb_fetch_ctrl;

  localparam logic [31:0] RST_PC = 32'h0000_3000;
  localparam int M_IDLE  = 0;
  localparam int M_FETCH = 1;
  localparam int M_HOLD  = 2;
  localparam int M_HALT  = 3;

  typedef struct {
    logic        req;
    logic        valid;
    logic        halted;
    logic        align;
    logic [31:0] addr;
    logic        rst;
  } stat_t;

  typedef struct {
    logic [31:0] data;
    logic [31:0] pc;
  } item_t;

  logic clk;
  logic clr;
  fetch_ctrl_if bus ();

  fetch_ctrl #(.RESET_PC(32'h0000_3000)) dut (
    .clk (clk),
    .clr (clr),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int    tests = 0;
  int    fails = 0;
  stat_t stat_q[$];
  item_t instr_q[$];

  int          m_mode  = M_IDLE;
  logic [31:0] m_pc    = RST_PC;
  logic        m_align = 1'b0;
  int          m_accepts = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Model of the controller at transaction level: where it is, what PC it
  // points to, and which instruction decode should see next.
  task automatic cyc();
    stat_t s;
    item_t it;
    if (!clr) begin
      m_mode  = M_IDLE;
      m_pc    = RST_PC;
      m_align = 1'b0;
    end else if (bus.redirect) begin
      m_pc = bus.redirect_pc & 32'hFFFF_FFFC;
      if ((bus.redirect_pc % 4) != 0) m_align = 1'b1;
      m_mode = M_FETCH;
    end else if (m_mode == M_IDLE) begin
      m_mode = bus.halt ? M_HALT : M_FETCH;
    end else if (m_mode == M_FETCH && bus.imem_ready) begin
      it.data = bus.imem_rdata;
      it.pc   = m_pc;
      instr_q.push_back(it);
      m_mode = M_HOLD;
    end else if (m_mode == M_HOLD && bus.instr_ready) begin
      m_pc = m_pc + 32'd4;
      m_accepts++;
      m_mode = bus.halt ? M_HALT : M_FETCH;
    end
    s.req    = (m_mode == M_FETCH);
    s.valid  = (m_mode == M_HOLD);
    s.halted = (m_mode == M_HALT);
    s.align  = m_align;
    s.addr   = m_pc;
    s.rst    = !clr;
    stat_q.push_back(s);
    @(posedge clk);
    #2;
  endtask

  task automatic drive(input bit c, input bit mr, input bit ir, input bit rd,
                       input logic [31:0] rpc, input bit h, input bit rand_data);
    clr             = c;
    bus.imem_ready  = mr;
    bus.instr_ready = ir;
    bus.redirect    = rd;
    bus.redirect_pc = rpc;
    bus.halt        = h;
    bus.imem_rdata  = rand_data ? $urandom() : (m_pc ^ 32'hA5A5_0000);
    cyc();
  endtask

  task automatic run_until(input int target, input bit mr, input bit ir);
    int n = 0;
    while (m_mode != target && n < 50) begin
      drive(1'b1, mr, ir, 1'b0, '0, 1'b0, 1'b0);
      n++;
    end
    if (m_mode != target) begin
      fails++;
      $display("FAIL run_until: mode %0d expected %0d", m_mode, target);
    end
  endtask

  // Monitor: compares DUT outputs #1 after every rising edge.
  initial begin : monitor
    stat_t s;
    item_t cur;
    bit    prev_valid = 1'b0;
    cur.data = '0;
    cur.pc   = '0;
    forever begin
      @(posedge clk);
      #1;
      if (stat_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL stat_queue: got empty expected entry at %0t", $time);
      end else begin
        s = stat_q.pop_front();
        chk("imem_req",    {31'd0, bus.imem_req},    {31'd0, s.req});
        chk("instr_valid", {31'd0, bus.instr_valid}, {31'd0, s.valid});
        chk("halted",      {31'd0, bus.halted},      {31'd0, s.halted});
        chk("align_err",   {31'd0, bus.align_err},   {31'd0, s.align});
        chk("imem_addr",   bus.imem_addr,            s.addr);
        if (s.rst) begin
          chk("rst_instr",    bus.instr,          32'd0);
          chk("rst_instr_pc", bus.instr_pc,       32'd0);
          chk("rst_plus4",    bus.instr_pc_plus4, 32'd4);
        end
      end
      if (bus.instr_valid) begin
        if (!prev_valid) begin
          if (instr_q.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL unexpected_instr: got pc %h expected none", bus.instr_pc);
          end else begin
            cur = instr_q.pop_front();
          end
        end
        chk("instr",          bus.instr,          cur.data);
        chk("instr_pc",       bus.instr_pc,       cur.pc);
        chk("instr_pc_plus4", bus.instr_pc_plus4, cur.pc + 32'd4);
      end
      prev_valid = bus.instr_valid;
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "timeout");
  end

  initial begin : stimulus
    logic [31:0] rpc;
    int          acc0;
    int          n;

    // Reset with hostile inputs.
    for (int i = 0; i < 2; i++)
      drive(1'b0, 1'b1, $urandom_range(0, 1), 1'b1, $urandom(), $urandom_range(0, 1), 1'b1);

    // Release and stream.
    for (int i = 0; i < 10; i++)
      drive(1'b1, 1'b1, 1'b1, 1'b0, '0, 1'b0, 1'b0);

    // Backpressure: memory delay then decode stall.
    drive(1'b1, 1'b0, 1'b0, 1'b1, 32'h0000_3000, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) drive(1'b1, 1'b0, 1'b0, 1'b0, '0, 1'b0, 1'b0);
    drive(1'b1, 1'b1, 1'b0, 1'b0, '0, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) drive(1'b1, 1'b0, 1'b0, 1'b0, '0, 1'b0, 1'b0);
    drive(1'b1, 1'b0, 1'b1, 1'b0, '0, 1'b0, 1'b0);
    drive(1'b1, 1'b0, 1'b0, 1'b0, '0, 1'b0, 1'b0);

    // Redirect colliding with a response, then with an acceptance.
    drive(1'b1, 1'b0, 1'b0, 1'b1, 32'h0000_3000, 1'b0, 1'b0);
    drive(1'b1, 1'b1, 1'b1, 1'b1, 32'h0000_3040, 1'b0, 1'b0);
    drive(1'b1, 1'b1, 1'b0, 1'b0, '0, 1'b0, 1'b0);
    drive(1'b1, 1'b0, 1'b1, 1'b1, 32'h0000_3040, 1'b0, 1'b0);
    drive(1'b1, 1'b0, 1'b0, 1'b0, '0, 1'b0, 1'b0);

    // Misaligned redirect, then ten accepted instructions.
    drive(1'b1, 1'b0, 1'b0, 1'b1, 32'h0000_3046, 1'b0, 1'b0);
    acc0 = m_accepts;
    n = 0;
    while (m_accepts - acc0 < 10 && n < 60) begin
      drive(1'b1, 1'b1, 1'b1, 1'b0, '0, 1'b0, 1'b0);
      n++;
    end

    // Halt at acceptance of 0x3004, idle in HALT, then wrap from 0xFFFF_FFFC.
    drive(1'b1, 1'b0, 1'b0, 1'b1, 32'h0000_3000, 1'b0, 1'b0);
    run_until(M_HOLD, 1'b1, 1'b0);
    drive(1'b1, 1'b0, 1'b1, 1'b0, '0, 1'b0, 1'b0);
    run_until(M_HOLD, 1'b1, 1'b0);
    drive(1'b1, 1'b0, 1'b1, 1'b0, '0, 1'b1, 1'b0);
    for (int i = 0; i < 20; i++)
      drive(1'b1, $urandom_range(0, 1), $urandom_range(0, 1), 1'b0, '0,
            $urandom_range(0, 1), 1'b1);
    drive(1'b1, 1'b0, 1'b0, 1'b1, 32'hFFFF_FFFC, 1'b0, 1'b0);
    run_until(M_HOLD, 1'b1, 1'b0);
    drive(1'b1, 1'b0, 1'b1, 1'b0, '0, 1'b0, 1'b0);
    drive(1'b1, 1'b0, 1'b0, 1'b0, '0, 1'b0, 1'b0);

    // Random traffic including sparse resets, redirects and halts.
    for (int i = 0; i < 400; i++) begin
      rpc = $urandom();
      if ($urandom_range(0, 3) != 0) rpc = rpc & 32'hFFFF_FFFC;
      drive($urandom_range(0, 49) != 0, $urandom_range(0, 1), $urandom_range(0, 1),
            $urandom_range(0, 11) == 0, rpc, $urandom_range(0, 7) == 0, 1'b1);
    end

    chk("instr_q_drained", instr_q.size(), 32'd0);
    chk("stat_q_drained",  stat_q.size(),  32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/fetch_ctrl.md
Name: fetch_ctrl

Overview:
- Instruction-fetch sequencer for the MIPS core. Owns the program counter and issues word addresses to instruction memory over a variable-latency request/ready handshake.
- Presents each fetched instruction, with its PC and PC+4, to decode through a valid/ready handshake.
- Handles control-flow redirects from branch/jump/jr resolution, plus halt.
- Replaces the free-running PC register wherever memory latency or decode backpressure exists.

Parameters:
- RESET_PC, 32'h0000_3000, PC value loaded on reset.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- clr  in  1  synchronous, active-low reset (0 = reset).
- imem_req  out  1  fetch request to instruction memory.
- imem_addr  out  32  fetch address; equals current PC.
- imem_ready  in  1  instruction memory response valid this cycle.
- imem_rdata  in  32  instruction word; valid when imem_ready=1.
- instr_valid  out  1  instruction held for decode.
- instr  out  32  held instruction word.
- instr_pc  out  32  address of held instruction.
- instr_pc_plus4  out  32  instr_pc + 4, modulo 2^32.
- instr_ready  in  1  decode accepts the held instruction this cycle.
- redirect  in  1  control-flow change; load redirect_pc.
- redirect_pc  in  32  redirect target.
- halt  in  1  stop fetching after the current instruction is accepted.
- halted  out  1  controller is in HALT.
- align_err  out  1  sticky flag: a misaligned redirect target was received.

Behaviour:
- State machine has four states: IDLE, FETCH, HOLD, HALT. All outputs are derived from registered state; there are no combinational input-to-output paths except none.
- Reset (clr=0 at clock edge):
  - state=IDLE, pc=RESET_PC.
  - instr=0, instr_pc=0, align_err=0.
  - Resulting outputs: imem_req=0, instr_valid=0, halted=0, imem_addr=RESET_PC, instr_pc_plus4=4.
  - Reset overrides every other input and aborts any fetch in flight.
- Priority within a cycle: reset > redirect > halt > handshake.
- Redirect handling:
  - redirect=1 in any state: pc <= {redirect_pc[31:2], 2'b00}; next state is FETCH.
  - If redirect_pc[1:0] != 0, align_err <= 1. align_err stays set until reset.
- IDLE: next state is HALT if halt=1, otherwise FETCH.
- FETCH:
  - Outputs: imem_req=1, imem_addr=pc.
  - If redirect=1, any response arriving the same cycle (imem_ready=1) is discarded.
  - Else if imem_ready=1: instr <= imem_rdata, instr_pc <= pc; go to HOLD.
  - Else remain in FETCH. Request and address stay stable with no timeout.
- HOLD:
  - Outputs: instr_valid=1, imem_req=0.
  - instr, instr_pc and instr_pc_plus4 are held stable while waiting.
  - redirect=1 drops the held instruction unconsumed, even if instr_ready=1. instr_valid is 0 from the next cycle.
  - Else if instr_ready=1: pc <= pc + 4 (wraps 0xFFFF_FFFC -> 0x0000_0000). Go to HALT if halt=1, otherwise FETCH.
  - Else remain in HOLD.
- HALT:
  - Outputs: halted=1, imem_req=0, instr_valid=0, pc frozen.
  - Exits only on redirect (to FETCH) or on reset.
- halt is sampled only in IDLE and at HOLD acceptance. A halt level in FETCH is ignored until the next acceptance.
- Throughput: at most one instruction per two cycles (FETCH then HOLD). Minimum latency from request to instr_valid is one cycle when imem_ready=1 immediately.
- Width rules: all addresses are 32-bit unsigned, and addition is modulo 2^32.

Test Plan:
- Reset: hold clr=0 for 2 cycles with random inputs, including imem_ready=1 and redirect=1.
  -> Required: imem_req=0, instr_valid=0, halted=0, align_err=0 throughout.
  -> After release: 1 cycle in IDLE, then imem_req=1 with imem_addr=0x0000_3000.
- Streaming: imem_ready=1 and instr_ready=1 constantly; imem_rdata = address ^ 0xA5A5_0000.
  -> instr_pc sequence 0x3000, 0x3004, 0x3008, with instr_valid every other cycle.
  -> instr and instr_pc_plus4 (0x3004, 0x3008, 0x300C) match each instr_pc.
- Backpressure: imem_ready delayed 3 cycles, then instr_ready=0 for 4 cycles in HOLD.
  -> imem_addr stays 0x3000 during the wait.
  -> instr, instr_pc stable and imem_req=0 while backpressured.
  -> After acceptance, the next request is to 0x3004.
- Redirect collision: redirect=1 with redirect_pc=0x3040 in the same FETCH cycle as imem_ready=1.
  -> Response is dropped; no instr_valid for 0x3000.
  -> Next imem_addr=0x3040. Repeat in HOLD with instr_ready=1: the held instruction is not consumed, and the next fetch is at 0x3040.
- Misaligned redirect: redirect_pc=0x3046.
  -> align_err=1 from the next cycle and still 1 after 10 further accepted instructions.
  -> Fetch address 0x3044.
- Halt and wrap: halt=1 at acceptance of 0x3004.
  -> HALT with halted=1 and imem_req=0 for 20 cycles.
  -> Then redirect to 0xFFFF_FFFC: fetch issues; after acceptance, the next imem_addr is 0x0000_0000.
